// File: rtl/boot_sequencer.sv
// Program download sequencer: writes received words into imem at incrementing
// addresses and keeps the CPU in reset until a settle delay after download ends.
module boot_sequencer #(
    parameter int ADDR_WIDTH    = 12,
    parameter int DATA_WIDTH    = 32,
    parameter int MAX_WORDS     = 4096,
    parameter int RELEASE_DELAY = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  boot_req,
    input  logic                  word_valid,
    input  logic [DATA_WIDTH-1:0] word_data,
    output logic                  imem_wEn,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] imem_data,
    output logic                  cpu_reset,
    output logic                  boot_ready,
    output logic                  loading,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  overflow
);

    localparam int DLY_W = $clog2(RELEASE_DELAY + 1);
    localparam logic [DLY_W-1:0]    DLY_LAST  = DLY_W'(RELEASE_DELAY - 1);
    localparam logic [ADDR_WIDTH:0] COUNT_MAX = (ADDR_WIDTH + 1)'(MAX_WORDS);

    typedef enum logic [1:0] {
        ST_RELEASE,
        ST_RUN,
        ST_ARM,
        ST_LOAD
    } state_t;

    state_t                  state_reg,   state_next;
    logic [DLY_W-1:0]        dly_reg,     dly_next;
    logic                    wen_reg,     wen_next;
    logic [ADDR_WIDTH-1:0]   addr_reg,    addr_next;
    logic [DATA_WIDTH-1:0]   data_reg,    data_next;
    logic                    cpu_rst_reg, cpu_rst_next;
    logic                    ready_reg,   ready_next;
    logic                    loading_reg, loading_next;
    logic [ADDR_WIDTH:0]     count_reg,   count_next;
    logic                    ovf_reg,     ovf_next;
    logic                    take_word;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_RELEASE;
            dly_reg     <= '0;
            wen_reg     <= 1'b0;
            addr_reg    <= '0;
            data_reg    <= '0;
            cpu_rst_reg <= 1'b1;
            ready_reg   <= 1'b0;
            loading_reg <= 1'b0;
            count_reg   <= '0;
            ovf_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            dly_reg     <= dly_next;
            wen_reg     <= wen_next;
            addr_reg    <= addr_next;
            data_reg    <= data_next;
            cpu_rst_reg <= cpu_rst_next;
            ready_reg   <= ready_next;
            loading_reg <= loading_next;
            count_reg   <= count_next;
            ovf_reg     <= ovf_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        dly_next     = dly_reg;
        wen_next     = 1'b0;
        addr_next    = addr_reg;
        data_next    = data_reg;
        cpu_rst_next = cpu_rst_reg;
        ready_next   = ready_reg;
        loading_next = loading_reg;
        count_next   = count_reg;
        ovf_next     = ovf_reg;
        take_word    = 1'b0;

        case (state_reg)
            ST_RELEASE: begin
                cpu_rst_next = 1'b1;
                ready_next   = 1'b0;
                loading_next = 1'b0;
                dly_next     = dly_reg + 1'b1;
                if (dly_reg == DLY_LAST) begin
                    dly_next = '0;
                    if (boot_req) begin
                        state_next = ST_ARM;
                        ready_next = 1'b1;
                        count_next = '0;
                        ovf_next   = 1'b0;
                    end else begin
                        state_next   = ST_RUN;
                        cpu_rst_next = 1'b0;
                    end
                end
            end
            ST_RUN: begin
                if (boot_req) begin
                    state_next   = ST_ARM;
                    cpu_rst_next = 1'b1;
                    ready_next   = 1'b1;
                    loading_next = 1'b0;
                    count_next   = '0;
                    ovf_next     = 1'b0;
                end
            end
            ST_ARM: begin
                if (word_valid) begin
                    take_word    = 1'b1;
                    state_next   = ST_LOAD;
                    loading_next = 1'b1;
                end else if (!boot_req) begin
                    state_next   = ST_RELEASE;
                    dly_next     = '0;
                    ready_next   = 1'b0;
                    loading_next = 1'b0;
                end
            end
            ST_LOAD: begin
                take_word = word_valid;
                // A word arriving alongside the falling request is still written.
                if (!boot_req) begin
                    state_next   = ST_RELEASE;
                    dly_next     = '0;
                    ready_next   = 1'b0;
                    loading_next = 1'b0;
                end
            end
            default: begin
                state_next = ST_RELEASE;
                dly_next   = '0;
            end
        endcase

        // Saturate at the limit rather than wrapping onto already-written words.
        if (take_word) begin
            if (count_reg < COUNT_MAX) begin
                wen_next   = 1'b1;
                addr_next  = count_reg[ADDR_WIDTH-1:0];
                data_next  = word_data;
                count_next = count_reg + 1'b1;
            end else begin
                ovf_next = 1'b1;
            end
        end
    end

    assign imem_wEn   = wen_reg;
    assign imem_addr  = addr_reg;
    assign imem_data  = data_reg;
    assign cpu_reset  = cpu_rst_reg;
    assign boot_ready = ready_reg;
    assign loading    = loading_reg;
    assign word_count = count_reg;
    assign overflow   = ovf_reg;

endmodule
